// File: rtl/clk_freq_meter.sv
// ---------------------------------------------------------------------------
// clk_freq_meter
//
// Purpose: measures the frequency of an asynchronous signal. It counts the
// rising edges of sig_in over a gate window of GATE_CYCLES clkin cycles and
// reports the total with a valid/ready handshake. A single window is started
// with a start pulse. While cont is high, windows are repeated back to back,
// each one beginning after the previous result is accepted.
//
// Parameters:
//   GATE_CYCLES  gate window length in clkin cycles (2 or more)
//   CNT_W        width of the edge count result
//   EXP_MIN      lower bound of the optional range check
//   EXP_MAX      upper bound of the optional range check
//
// Ports:
//   clkin     in   sole clock, rising edge
//   reset     in   synchronous active-high reset
//   sig_in    in   asynchronous signal under measurement (< clkin/2)
//   start     in   single-window request, sampled in IDLE only
//   cont      in   continuous mode
//   count     out  saturating rising-edge count of the last window
//   valid     out  result available, held until accepted
//   ready     in   consumer accept
//   busy      out  high whenever the block is not idle
//   overflow  out  last window's count saturated
//   in_range  out  EXP_MIN <= count <= EXP_MAX (only with the macro below)
//
// Configuration macro: CLK_FREQ_METER_RANGE_CHECK_EN adds the in_range port
// and its registered comparator.
// ---------------------------------------------------------------------------
module clk_freq_meter #(
  parameter int GATE_CYCLES = 27000,
  parameter int CNT_W       = 16,
  parameter int EXP_MIN     = 0,
  parameter int EXP_MAX     = 65535
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             overflow
`ifdef CLK_FREQ_METER_RANGE_CHECK_EN
  ,
  output logic             in_range
`endif
);

  // Gate counter runs 0 .. GATE_CYCLES-1, so clog2 bits are enough.
  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  // Reject unusable parameter sets at elaboration time.
  if (GATE_CYCLES < 2 || EXP_MIN > EXP_MAX) begin : g_bad_params
    $error("clk_freq_meter: GATE_CYCLES must be >= 2 and EXP_MIN <= EXP_MAX");
  end

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    REPORT
  } state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q, sync3_q;
  logic             edgeDet;
  logic [GW-1:0]    gateCnt_q, gateCnt_d;
  logic [CNT_W-1:0] edgeCnt_q, edgeCnt_d;
  logic [CNT_W-1:0] edgeNext;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             loadResult;

  // Two flops resynchronise sig_in; the third is a delayed copy so a rising
  // edge shows up as exactly one cycle with stage 2 high and stage 3 low.
  always_ff @(posedge clkin) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sig_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign edgeDet = sync2_q & ~sync3_q;

  // Edge total including this cycle's edge, held at all-ones once it is
  // reached so a fast input can never wrap the result.
  always_comb begin
    edgeNext = edgeCnt_q;
    if (edgeDet && (edgeCnt_q != CNT_MAX)) begin
      edgeNext = edgeCnt_q + CNT_W'(1);
    end
  end

  // Next-state logic. Both ways into COUNT (a request from IDLE, or an
  // accepted result while cont is high) clear the counters so every window
  // starts from zero. The final COUNT cycle still contributes its edge,
  // which is why the result is taken from edgeNext rather than edgeCnt_q.
  always_comb begin
    state_d    = state_q;
    gateCnt_d  = gateCnt_q;
    edgeCnt_d  = edgeCnt_q;
    loadResult = 1'b0;
    case (state_q)
      IDLE: begin
        if (start || cont) begin
          state_d   = COUNT;
          gateCnt_d = '0;
          edgeCnt_d = '0;
        end
      end
      COUNT: begin
        edgeCnt_d = edgeNext;
        if (gateCnt_q == GATE_LAST) begin
          state_d    = REPORT;
          loadResult = 1'b1;
        end else begin
          gateCnt_d = gateCnt_q + GW'(1);
        end
      end
      REPORT: begin
        if (ready) begin
          if (cont) begin
            state_d   = COUNT;
            gateCnt_d = '0;
            edgeCnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result registers only change at the end of a window, so they stay
  // stable for the whole time the consumer holds off ready.
  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (loadResult) begin
      count_d    = edgeNext;
      overflow_d = (edgeNext == CNT_MAX);
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q    <= IDLE;
      gateCnt_q  <= '0;
      edgeCnt_q  <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gateCnt_q  <= gateCnt_d;
      edgeCnt_q  <= edgeCnt_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign valid    = (state_q == REPORT);
  assign busy     = (state_q != IDLE);

`ifdef CLK_FREQ_METER_RANGE_CHECK_EN
  logic inRange_q, inRange_d;

  // Range flag is registered alongside count so the two always agree.
  always_comb begin
    inRange_d = inRange_q;
    if (loadResult) begin
      inRange_d = (int'(edgeNext) >= EXP_MIN) && (int'(edgeNext) <= EXP_MAX);
    end
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      inRange_q <= 1'b0;
    end else begin
      inRange_q <= inRange_d;
    end
  end

  assign in_range = inRange_q;
`endif

endmodule

// File: tb/tb_clk_freq_meter.sv
// ---------------------------------------------------------------------------
// tb_clk_freq_meter
//
// Testbench for clk_freq_meter. The main instance uses a 100-cycle window and
// an 8-bit count; a second instance with a 4-bit count exercises saturation.
// sig_in is a square wave of selectable period. Every driven sig_in value is
// logged per cycle. A reference model watches start/cont/ready/reset, counts
// the rising edges of the logged waveform that fall inside each window
// (shifted by the two-cycle synchroniser latency) and queues the expected
// result. A monitor pops and compares whenever the DUT presents valid.
// ---------------------------------------------------------------------------
module tb_clk_freq_meter;

  localparam int G    = 100;
  localparam int W    = 8;
  localparam int EMIN = 24;
  localparam int EMAX = 26;
  localparam int GB   = 40;
  localparam int WB   = 4;
  localparam int HMAX = 60000;

  logic          clkin = 1'b0;
  logic          reset = 1'b1;
  logic          sig_in = 1'b0;
  logic          start = 1'b0;
  logic          cont = 1'b0;
  logic          ready = 1'b0;
  logic [W-1:0]  count;
  logic          valid, busy, overflow, in_range;

  logic          startB = 1'b0;
  logic          readyB = 1'b0;
  logic [WB-1:0] countB;
  logic          validB, busyB, overflowB, inRangeB;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cnt;
    bit ovf;
    bit inr;
    int vcyc;
  } exp_t;

  exp_t expQ[$];

  int cyc        = 0;
  int sigPeriod  = 4;
  bit sigLevel   = 1'b0;
  int lastPeriod = 4;
  int ph         = 0;
  bit hist[0:HMAX-1];

  clk_freq_meter #(
    .GATE_CYCLES(G),
    .CNT_W      (W),
    .EXP_MIN    (EMIN),
    .EXP_MAX    (EMAX)
  ) dut (
    .clkin   (clkin),
    .reset   (reset),
    .sig_in  (sig_in),
    .start   (start),
    .cont    (cont),
    .count   (count),
    .valid   (valid),
    .ready   (ready),
    .busy    (busy),
    .overflow(overflow)
`ifdef CLK_FREQ_METER_RANGE_CHECK_EN
    ,
    .in_range(in_range)
`endif
  );

  clk_freq_meter #(
    .GATE_CYCLES(GB),
    .CNT_W      (WB)
  ) dutB (
    .clkin   (clkin),
    .reset   (reset),
    .sig_in  (sig_in),
    .start   (startB),
    .cont    (1'b0),
    .count   (countB),
    .valid   (validB),
    .ready   (readyB),
    .busy    (busyB),
    .overflow(overflowB)
`ifdef CLK_FREQ_METER_RANGE_CHECK_EN
    ,
    .in_range(inRangeB)
`endif
  );

`ifndef CLK_FREQ_METER_RANGE_CHECK_EN
  assign in_range = 1'b0;
  assign inRangeB = 1'b0;
`endif

  always #5 clkin = ~clkin;

  // Hard stop in case something never finishes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Square-wave driver. cyc numbers the interval between rising edges, and
  // hist[cyc] is the sig_in value held during that interval.
  always @(posedge clkin) begin
    #1;
    cyc = cyc + 1;
    if (sigPeriod != lastPeriod) begin
      ph         = 0;
      lastPeriod = sigPeriod;
    end
    if (sigPeriod < 2) begin
      sig_in = sigLevel;
    end else begin
      sig_in = (ph < sigPeriod / 2);
      ph     = (ph + 1) % sigPeriod;
    end
    if (cyc < HMAX) hist[cyc] = sig_in;
  end

  function automatic bit histAt(input int j);
    if (j < 0 || j >= HMAX) return 1'b0;
    return hist[j];
  endfunction

  // Rising edges of the logged waveform whose new level sits in [lo, hi].
  function automatic int risingEdges(input int lo, input int hi);
    int n = 0;
    for (int j = lo; j <= hi; j++) begin
      if (histAt(j) && !histAt(j - 1)) n++;
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model. A window that starts being counted in interval n0
  // covers intervals n0 .. n0+G-1; an input edge appears two intervals later
  // at the detector, so the edges counted are those of hist[n0-2 .. n0+G-3].
  initial begin
    bit   haveStart;
    bit   aborted;
    bit   done;
    int   n0;
    int   edges;
    exp_t e;
    haveStart = 1'b0;
    n0        = 0;
    forever begin
      if (!haveStart) begin
        do @(posedge clkin); while (reset || !(start || cont));
        n0 = cyc + 1;
      end
      haveStart = 1'b0;
      aborted   = 1'b0;
      for (int k = 0; k < G && !aborted; k++) begin
        @(posedge clkin);
        if (reset) aborted = 1'b1;
      end
      if (!aborted) begin
        edges  = risingEdges(n0 - 2, n0 + G - 3);
        e.cnt  = (edges > (1 << W) - 1) ? (1 << W) - 1 : edges;
        e.ovf  = (edges >= (1 << W) - 1);
        e.inr  = (e.cnt >= EMIN) && (e.cnt <= EMAX);
        e.vcyc = n0 + G;
        expQ.push_back(e);
        done = 1'b0;
        while (!done) begin
          @(posedge clkin);
          if (reset) begin
            done = 1'b1;
          end else if (ready) begin
            done = 1'b1;
            if (cont) begin
              haveStart = 1'b1;
              n0        = cyc + 1;
            end
          end
        end
      end
    end
  end

  // Monitor: the first valid cycle of a result pops the next expectation;
  // every cycle that valid stays high is compared against that same entry.
  bit   holding = 1'b0;
  exp_t cur;

  always @(negedge clkin) begin
    if (valid) begin
      if (!holding) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedValid", 32'd1, 32'd0);
        end else begin
          cur     = expQ.pop_front();
          holding = 1'b1;
          checkOutput("validCycle", cyc, cur.vcyc);
        end
      end
      if (holding) begin
        checkOutput("count", 32'(count), cur.cnt);
        checkOutput("overflow", 32'(overflow), 32'(cur.ovf));
        checkOutput("busyInReport", 32'(busy), 32'd1);
`ifdef CLK_FREQ_METER_RANGE_CHECK_EN
        checkOutput("inRange", 32'(in_range), 32'(cur.inr));
`endif
        if (ready) holding = 1'b0;
      end
    end else begin
      holding = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clkin);
      #2;
    end
  endtask

  task automatic waitValid(input int budget, input string name, output int waited);
    waited = 0;
    while (!valid && waited < budget) begin
      tick(1);
      waited++;
    end
    checkOutput(name, 32'(valid), 32'd1);
  endtask

  task automatic ackResult(input int delay);
    tick(delay);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, "Valid"}, 32'(valid), 32'd0);
    checkOutput({name, "Busy"}, 32'(busy), 32'd0);
    checkOutput({name, "Count"}, 32'(count), 32'd0);
    checkOutput({name, "Overflow"}, 32'(overflow), 32'd0);
`ifdef CLK_FREQ_METER_RANGE_CHECK_EN
    checkOutput({name, "InRange"}, 32'(in_range), 32'd0);
`endif
  endtask

  // One randomised measurement: optional continuous second window, a start
  // pulse during COUNT that must be ignored, a period change mid-window and
  // random consumer backpressure.
  task automatic applyStimulus(input int period, input bit useCont,
                               input int readyDelay, input int midDelay);
    int waited;
    sigPeriod = period;
    sigLevel  = 1'($urandom_range(0, 1));
    cont      = useCont;
    start     = 1'b1;
    tick(1);
    start = 1'b0;
    tick(midDelay);
    start = 1'b1;
    tick(1);
    start     = 1'b0;
    sigPeriod = $urandom_range(0, 9);
    waitValid(G + 20, "randValid", waited);
    tick(readyDelay);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    if (useCont) begin
      cont = 1'b0;
      waitValid(G + 20, "randContValid", waited);
      ackResult($urandom_range(0, 4));
    end
    tick(2);
    checkOutput("randIdle", 32'(busy), 32'd0);
  endtask

  initial begin
    int waited;
    hist[0] = 1'b0;

    // Reset state.
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
    checkIdleOutputs("reset");
    tick(4);

    // Single window, period 4: 25 edges, valid 101 cycles after start.
    sigPeriod = 4;
    start     = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("busyInCount", 32'(busy), 32'd1);
    waitValid(G + 20, "singleValid", waited);
    checkOutput("latency", waited + 1, 32'd101);
    checkOutput("singleCount", 32'(count), 32'd25);
    checkOutput("singleOverflow", 32'(overflow), 32'd0);
`ifdef CLK_FREQ_METER_RANGE_CHECK_EN
    checkOutput("period4InRange", 32'(in_range), 32'd1);
`endif
    ackResult(0);
    checkOutput("afterAckValid", 32'(valid), 32'd0);
    checkOutput("afterAckBusy", 32'(busy), 32'd0);

    // Continuous mode with 10 cycles of backpressure, then cont dropped
    // during the second window.
    cont = 1'b1;
    tick(1);
    waitValid(G + 20, "contValid", waited);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checkOutput("holdValid", 32'(valid), 32'd1);
      checkOutput("holdCount", 32'(count), 32'd25);
    end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    checkOutput("contRestartBusy", 32'(busy), 32'd1);
    checkOutput("contRestartValid", 32'(valid), 32'd0);
    tick(30);
    cont = 1'b0;
    waitValid(G + 20, "contSecondValid", waited);
    checkOutput("contSecondCount", 32'(count), 32'd25);
    ackResult(0);
    tick(2);
    checkOutput("contEndsIdle", 32'(busy), 32'd0);

    // Reset in the 50th cycle of COUNT abandons the window.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(49);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checkIdleOutputs("midReset");
    tick(G + 10);
    checkOutput("noValidAfterReset", 32'(valid), 32'd0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    waitValid(G + 20, "postResetValid", waited);
    checkOutput("postResetCount", 32'(count), 32'd25);
    ackResult(2);

    // Period 5: 20 edges, outside the expected range.
    sigPeriod = 5;
    start     = 1'b1;
    tick(1);
    start = 1'b0;
    waitValid(G + 20, "period5Valid", waited);
    checkOutput("period5Count", 32'(count), 32'd20);
`ifdef CLK_FREQ_METER_RANGE_CHECK_EN
    checkOutput("period5InRange", 32'(in_range), 32'd0);
`endif
    ackResult(1);

    // sig_in held high through reset and start: nothing to count.
    sigPeriod = 0;
    sigLevel  = 1'b1;
    reset     = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(5);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    waitValid(G + 20, "stuckHighValid", waited);
    checkOutput("stuckHighCount", 32'(count), 32'd0);
    ackResult(0);

    // Randomised windows.
    for (int i = 0; i < 10; i++) begin
      applyStimulus($urandom_range(2, 9), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 6), $urandom_range(5, 60));
    end

    // Narrow counter: period 2 over 40 cycles gives 20 edges, held at 15.
    sigPeriod = 2;
    tick(4);
    startB = 1'b1;
    tick(1);
    startB = 1'b0;
    waited = 0;
    while (!validB && waited < GB + 20) begin
      tick(1);
      waited++;
    end
    checkOutput("satValid", 32'(validB), 32'd1);
    checkOutput("satCount", 32'(countB), 32'd15);
    checkOutput("satOverflow", 32'(overflowB), 32'd1);
    readyB = 1'b1;
    tick(1);
    readyB = 1'b0;
    checkOutput("satAckBusy", 32'(busyB), 32'd0);

    tick(5);
    checkOutput("queueEmpty", expQ.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_freq_meter.md
CLK_FREQ_METER -- requirements
Module: clk_freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 27000, giving the measurement window length in clkin cycles (1 ms at 27 MHz); legal range is 2 or more.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the edge count result.
REQ-003 SHALL have parameter EXP_MIN, default 0, giving the lower bound of the range check.
REQ-004 SHALL have parameter EXP_MAX, default 65535, giving the upper bound of the range check.
REQ-005 clkin  input  1  sole clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 sig_in  input  1  asynchronous signal under measurement (for example a divided PLL output); its frequency SHALL be below clkin/2.
REQ-008 start  input  1  single-window request; sampled in IDLE only.
REQ-009 cont  input  1  continuous mode; while high, a new window begins after each accepted result.
REQ-010 count  output  CNT_W  rising-edge count of the last completed window.
REQ-011 valid  output  1  count is valid; held until accepted.
REQ-012 ready  input  1  consumer accept; a transfer occurs on a cycle where valid and ready are both high.
REQ-013 busy  output  1  high whenever the state is not IDLE.
REQ-014 overflow  output  1  the last window's count saturated.
REQ-015 in_range  output  1  EXP_MIN <= count <= EXP_MAX; this port SHALL exist only when the configuration macro is defined.

Function
REQ-016 sig_in SHALL pass through a 2-flop synchronizer followed by a third delay flop; an edge is a cycle where stage 2 is 1 and stage 3 is 0.
REQ-017 The state machine SHALL have exactly three states: IDLE, COUNT and REPORT.
REQ-018 IDLE: if start or cont is sampled high in cycle t, the block SHALL enter COUNT at t+1 with the gate counter and edge counter cleared.
REQ-019 COUNT SHALL last exactly GATE_CYCLES cycles (t+1 through t+GATE_CYCLES), counting every edge detected in those cycles, including the final cycle.
REQ-020 At the end of COUNT, the edge total SHALL load into count, overflow SHALL load, and the state SHALL become REPORT; valid SHALL be high from cycle t+GATE_CYCLES+1.
REQ-021 The edge counter SHALL saturate at 2^CNT_W-1 and SHALL never wrap; reaching saturation during a window SHALL set that window's overflow.
REQ-022 REPORT: valid, count, overflow and in_range SHALL remain stable until valid and ready are both high.
REQ-023 On that transfer: if cont is high, the next state SHALL be COUNT with counters cleared; otherwise the next state SHALL be IDLE. valid SHALL drop in the next cycle in either case.
REQ-024 Edges SHALL NOT be counted in IDLE or REPORT; dead time during backpressure is accepted behaviour.
REQ-025 start SHALL be ignored in COUNT and REPORT.
REQ-026 If start and cont are both high in IDLE, one COUNT entry SHALL occur and continuous mode SHALL govern.
REQ-027 Lowering cont during COUNT SHALL finish the current window, report it, and then return to IDLE.

Reset
REQ-028 Reset SHALL force state IDLE and clear all synchronizer flops, counters, count, valid, overflow, busy and in_range to 0.
REQ-029 Reset SHALL take priority over all other inputs in the same cycle; reset during COUNT or REPORT SHALL abandon the window with no valid pulse.
REQ-030 After reset, the first start SHALL produce a full GATE_CYCLES window.

Configuration
REQ-031 Macro CLK_FREQ_METER_RANGE_CHECK_EN, when defined, SHALL compile in the in_range port and a registered comparison that updates together with count.
REQ-032 When CLK_FREQ_METER_RANGE_CHECK_EN is undefined, the in_range port and comparator SHALL be absent, with all other behaviour identical.

Verification
REQ-033 GATE_CYCLES=100, CNT_W=8; sig_in period 4 clkin cycles; start pulse -> valid high 101 cycles after start, count=25, overflow=0.
REQ-034 CNT_W=4; sig_in period 2; start -> count=15, overflow=1, no wrap.
REQ-035 cont=1, ready low for 10 cycles in REPORT -> count/valid stable for all 10 cycles; ready high -> COUNT entered next cycle, second result=25.
REQ-036 reset asserted at cycle 50 of COUNT -> next cycle state IDLE with all outputs 0 and no valid; new start -> count=25 after a full window.
REQ-037 Macro defined, EXP_MIN=24, EXP_MAX=26: period 4 -> in_range=1; period 5 (count=20) -> in_range=0.
REQ-038 sig_in held at 1 through reset release and start -> count=0.
